// File: rtl/sram_responder.sv
// Behavioural asynchronous-SRAM target: 2^AW x 16 array behind a CE/OE/WE/byte-lane bus,
// with read/write activity counters, a sticky out-of-range flag and a debug read port.
module sram_responder #(
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [19:0]   SRAM_ADDR,
  inout  logic [15:0]   SRAM_DQ,
  input  logic          SRAM_CE_N,
  input  logic          SRAM_OE_N,
  input  logic          SRAM_WE_N,
  input  logic          SRAM_UE_N,
  input  logic          SRAM_LE_N,
  input  logic          clr_stats,
  input  logic [AW-1:0] dbg_addr,
  output logic [15:0]   dbg_data,
  output logic [7:0]    rd_count,
  output logic [7:0]    wr_count,
  output logic          err_range
);

  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    MODE_IDLE,
    MODE_WRITE,
    MODE_READ,
    MODE_DESEL
  } mode_e;

  mode_e       mode;
  logic        in_range;
  logic [AW-1:0] idx;
  logic [15:0] rd_word;
  logic [15:0] dq_out;
  logic        dq_drive;

  logic [15:0] mem_q [DEPTH];
  logic [7:0]  rd_cnt_q, rd_cnt_d;
  logic [7:0]  wr_cnt_q, wr_cnt_d;
  logic        err_q, err_d;

  // WE_N dominates OE_N, so a write never turns the data bus around.
  always_comb begin
    mode = MODE_IDLE;
    if (!SRAM_CE_N) begin
      if (!SRAM_WE_N)      mode = MODE_WRITE;
      else if (!SRAM_OE_N) mode = MODE_READ;
      else                 mode = MODE_DESEL;
    end
  end

  assign in_range = ((SRAM_ADDR >> AW) == 20'd0);
  assign idx      = SRAM_ADDR[AW-1:0];
  assign rd_word  = in_range ? mem_q[idx] : '0;

  always_comb begin
    dq_out   = {SRAM_UE_N ? 8'h00 : rd_word[15:8], SRAM_LE_N ? 8'h00 : rd_word[7:0]};
    dq_drive = rst_n && (mode == MODE_READ) && (!SRAM_UE_N || !SRAM_LE_N);
  end

  assign SRAM_DQ  = dq_drive ? dq_out : 'z;
  assign dbg_data = mem_q[dbg_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mode == MODE_WRITE && in_range) begin
      if (!SRAM_UE_N) mem_q[idx][15:8] <= SRAM_DQ[15:8];
      if (!SRAM_LE_N) mem_q[idx][7:0]  <= SRAM_DQ[7:0];
    end
  end

  // Clear wins over same-edge increments and error capture.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    err_d    = err_q;
    if (clr_stats) begin
      rd_cnt_d = '0;
      wr_cnt_d = '0;
      err_d    = 1'b0;
    end else begin
      if (mode == MODE_READ && rd_cnt_q != 8'hFF)  rd_cnt_d = rd_cnt_q + 8'd1;
      if (mode == MODE_WRITE && wr_cnt_q != 8'hFF) wr_cnt_d = wr_cnt_q + 8'd1;
      if ((mode == MODE_READ || mode == MODE_WRITE) && !in_range) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      err_q    <= err_d;
    end
  end

  assign rd_count  = rd_cnt_q;
  assign wr_count  = wr_cnt_q;
  assign err_range = err_q;

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter AW, default 4: implemented word-address bits; depth is 2^AW words of 16 bits.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 SRAM_ADDR  input  20  word address from the initiator.
REQ-005 SRAM_DQ  inout  16  bidirectional data bus; high-Z unless a read is active.
REQ-006 SRAM_CE_N  input  1  chip enable, active low.
REQ-007 SRAM_OE_N  input  1  output enable, active low.
REQ-008 SRAM_WE_N  input  1  write enable, active low.
REQ-009 SRAM_UE_N  input  1  upper byte lane enable (DQ[15:8]), active low.
REQ-010 SRAM_LE_N  input  1  lower byte lane enable (DQ[7:0]), active low.
REQ-011 clr_stats  input  1  synchronous clear of counters and error flag.
REQ-012 dbg_addr  input  AW  debug read address, independent of the bus.
REQ-013 dbg_data  output  16  memory word at dbg_addr, combinational.
REQ-014 rd_count  output  8  saturating count of read cycles.
REQ-015 wr_count  output  8  saturating count of write cycles.
REQ-016 err_range  output  1  sticky flag: access to an address >= 2^AW.

Function
REQ-017 Access modes, decoded every cycle: IDLE if CE_N=1; WRITE if CE_N=0 and WE_N=0; READ if CE_N=0, WE_N=1, OE_N=0; otherwise (CE_N=0, WE_N=1, OE_N=1) DESELECT.
REQ-018 WE_N dominates OE_N; WE_N=0 with OE_N=0 is a WRITE, and DQ stays high-Z.
REQ-019 WRITE: at the rising edge, each lane with its enable low stores its DQ byte at SRAM_ADDR[AW-1:0]; lanes with the enable high keep their old value.
REQ-020 READ: DQ is driven combinationally from the array at SRAM_ADDR[AW-1:0], with zero-cycle latency, so the initiator can sample the word at the same edge that changes the address.
REQ-021 READ lane gating: a disabled lane drives 8'h00 while the other lane drives its byte; if both lanes are disabled, DQ is high-Z.
REQ-022 Out of range (SRAM_ADDR[19:AW] != 0) during READ or WRITE: the write is suppressed, read data is 16'h0000 on the enabled lanes, and err_range is set at the next edge.
REQ-023 rd_count increments by 1 at each edge sampled in READ, and wr_count at each edge sampled in WRITE.
REQ-024 Both counters saturate at 8'hFF and never wrap.
REQ-025 Counters count out-of-range accesses as well as in-range ones.
REQ-026 clr_stats=1 at an edge zeroes rd_count, wr_count and err_range.
REQ-027 clr_stats has priority over a simultaneous increment or error set; the memory write in that cycle still occurs.
REQ-028 IDLE and DESELECT change no state.
REQ-029 Multi-cycle strobes count each sampled edge; a write held for 3 edges gives wr_count +3 with the same final data.
REQ-030 dbg_data reflects a write from the edge after the write.
REQ-031 The array is write-first only across edges; a same-address READ in the cycle after a WRITE returns the new data.
REQ-032 DQ is never driven while WE_N=0 or CE_N=1.

Reset
REQ-033 rst_n=0 asynchronously clears all 2^AW words to 16'h0000, rd_count and wr_count to 0, and err_range to 0, and releases DQ to high-Z.
REQ-034 If reset is asserted during a WRITE cycle, that write is lost, and the word reads 16'h0000 after reset.
REQ-035 Reset release takes effect at the first rising edge with rst_n=1; no access is lost at that edge.

Verification
REQ-036 Write/read, both lanes: write 16'h00A5 to addresses 0..3, then read 0..3 with OE_N=0 -> DQ=00A5 at each address; wr_count=4, rd_count=4.
REQ-037 Byte lanes: write 16'h1234 to address 1, then write 16'hABCD with UE_N=1, LE_N=0 -> word reads 16'h12CD; a read with LE_N=1 shows DQ=16'h1200.
REQ-038 Out of range: with AW=4, write to address 20'h00010 -> word 0 unchanged and err_range=1 at the next edge; a read there returns 16'h0000.
REQ-039 Contention: CE_N=0, WE_N=0, OE_N=0 -> DQ stays high-Z (the bench drives it), the write commits, and rd_count is unchanged.
REQ-040 Saturation/clear: 300 read edges -> rd_count=8'hFF; clr_stats pulsed during a read edge -> rd_count=0, not 1.
REQ-041 Reset mid-op: rst_n low while writing 16'hBEEF to address 2 -> dbg_addr=2 shows 16'h0000, counters are 0, and DQ is high-Z immediately.
